// File: rtl/in_fifo_rd_ctrl.sv
// Read-side controller for IN_FIFO: sequences FIFO reset/settle, gates RDEN on
// data and downstream room, and buffers captured words in a 2-entry stream buffer.
module in_fifo_rd_ctrl #(
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned RST_WAIT   = 8
) (
   input  logic        RDCLK,
   input  logic        RESET,
   input  logic        EN,
   input  logic        FLUSH,
   input  logic        EMPTY,
   input  logic        ALMOSTEMPTY,
   input  logic [7:0]  Q0,
   input  logic [7:0]  Q1,
   input  logic [7:0]  Q2,
   input  logic [7:0]  Q3,
   input  logic [7:0]  Q4,
   input  logic [7:0]  Q5,
   input  logic [7:0]  Q6,
   input  logic [7:0]  Q7,
   input  logic [7:0]  Q8,
   input  logic [7:0]  Q9,
   output logic        RDEN,
   output logic        FIFO_RESET,
   output logic [79:0] M_DATA,
   output logic        M_VALID,
   input  logic        M_READY,
   output logic        BUSY,
   output logic [15:0] RD_COUNT
);

   localparam int unsigned DW  = 80;
   localparam int unsigned CW  = 8;
   localparam logic [CW-1:0] CNT_HOLD   = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] CNT_SETTLE = CW'(RST_WAIT - 1);

   typedef enum logic [1:0] {HOLD, SETTLE, RUN} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          fifo_reset_c, busy_c, run_c;

   logic          inflight;
   logic [1:0]    occ;
   logic [DW-1:0] mem0, mem1;
   logic [15:0]   count;
   logic [DW-1:0] q_word;
   logic          pop, push, room;

   // State register; counter holds remaining cycles of HOLD/SETTLE minus one
   always_ff @(posedge RDCLK) begin
      if (RESET) begin
         state <= HOLD;
         cnt   <= CNT_HOLD;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next state: FLUSH restarts the reset sequence from any state
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (FLUSH) begin
         state_nx = HOLD;
         cnt_nx   = CNT_HOLD;
      end else begin
         case (state)
            HOLD: begin
               if (cnt == '0) begin
                  state_nx = SETTLE;
                  cnt_nx   = CNT_SETTLE;
               end else begin
                  cnt_nx = cnt - CW'(1);
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  state_nx = RUN;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt - CW'(1);
               end
            end
            RUN:     state_nx = RUN;
            default: begin
               state_nx = HOLD;
               cnt_nx   = CNT_HOLD;
            end
         endcase
      end
   end

   // State decode
   always_comb begin
      fifo_reset_c = 1'b0;
      busy_c       = 1'b1;
      run_c        = 1'b0;
      case (state)
         HOLD:    fifo_reset_c = 1'b1;
         SETTLE:  fifo_reset_c = 1'b0;
         RUN: begin
            busy_c = 1'b0;
            run_c  = 1'b1;
         end
         default: fifo_reset_c = 1'b1;
      endcase
   end

   assign FIFO_RESET = fifo_reset_c;
   assign BUSY       = busy_c;

   assign q_word = {Q9, Q8, Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0};
   assign pop    = (occ != 2'd0) & M_READY;
   assign push   = inflight & ~FLUSH;
   // Words owed to the buffer (held + in flight) after this cycle's pop must stay below 2
   assign room   = (3'(occ) + 3'(inflight)) < (3'd2 + 3'(pop));
   assign RDEN   = run_c & EN & ~FLUSH & ~RESET & ~EMPTY & room & ~(ALMOSTEMPTY & inflight);

   assign M_VALID  = (occ != 2'd0);
   assign M_DATA   = mem0;
   assign RD_COUNT = count;

   // In-order 2-entry buffer, mem0 is the head
   always_ff @(posedge RDCLK) begin
      if (RESET) begin
         inflight <= 1'b0;
         occ      <= 2'd0;
         mem0     <= '0;
         mem1     <= '0;
         count    <= '0;
      end else begin
         inflight <= RDEN;
         if (pop) count <= count + 16'd1;
         if (FLUSH) begin
            occ <= 2'd0;
         end else begin
            case ({push, pop})
               2'b11: begin
                  if (occ == 2'd1) begin
                     mem0 <= q_word;
                  end else begin
                     mem0 <= mem1;
                     mem1 <= q_word;
                  end
               end
               2'b01: begin
                  mem0 <= mem1;
                  occ  <= occ - 2'd1;
               end
               2'b10: begin
                  if (occ == 2'd0) mem0 <= q_word;
                  else             mem1 <= q_word;
                  occ <= occ + 2'd1;
               end
               default: occ <= occ;
            endcase
         end
      end
   end

endmodule

// File: doc/in_fifo_rd_ctrl.md
# in_fifo_rd_ctrl

Read-side controller for the IN_FIFO hard block in the input capture path. It runs on the FIFO read clock and sequences the FIFO reset and post-reset settling. It issues RDEN only when data is present and downstream has room, and captures the ten 8-bit channels into a 2-entry output buffer presented as an 80-bit valid/ready stream. It replaces ad-hoc RDEN tie-offs in top-level wrappers.

## Interface
Parameters:
- RST_CYCLES, 4: cycles FIFO_RESET is held high after RESET deasserts or after a flush (1-255).
- RST_WAIT, 8: settling cycles after FIFO_RESET falls before reads are allowed (1-255).

Ports:
- RDCLK  in  1  sole clock; all logic rising-edge.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  read enable; 0 stops new RDEN, buffered words still drain.
- FLUSH  in  1  pulse; discards buffer and FIFO contents via FIFO_RESET.
- EMPTY  in  1  from IN_FIFO.
- ALMOSTEMPTY  in  1  from IN_FIFO.
- Q0..Q9  in  8 each  from IN_FIFO.
- RDEN  out  1  to IN_FIFO.
- FIFO_RESET  out  1  to IN_FIFO RESET.
- M_DATA  out  80  {Q9,...,Q0} of head word.
- M_VALID  out  1  head word valid.
- M_READY  in  1  downstream accept.
- BUSY  out  1  high in any state other than RUN.
- RD_COUNT  out  16  accepted-word count.

## Operation
- States: HOLD (FIFO_RESET=1, counter from RST_CYCLES), SETTLE (FIFO_RESET=0, counter from RST_WAIT), RUN.
- RESET=1 forces HOLD. HOLD→SETTLE when count expires; SETTLE→RUN when count expires.
- RUN + FLUSH=1 → HOLD next cycle. Buffer is emptied, the in-flight read is dropped, M_VALID=0.
- FLUSH in HOLD/SETTLE reloads HOLD (restart).
- pop = M_VALID & M_READY. inflight = RDEN registered (1 bit). occ = buffer occupancy 0..2.
- RDEN (combinational from registered state plus inputs) = RUN & EN & ~FLUSH & ~EMPTY & (occ + inflight - pop < 2) & ~(ALMOSTEMPTY & inflight).
- Consequence of the last term: when ALMOSTEMPTY=1, RDEN is never asserted on two consecutive cycles. This guards against a stale EMPTY.
- Read latency: Q is valid the cycle after RDEN and is written into the buffer at the end of that cycle.
- Buffer is in-order, 2 entries. Push and pop in the same cycle leave occ unchanged. The buffer never overflows by construction.
- M_DATA holds stable while M_VALID=1 and M_READY=0.
- RD_COUNT increments on each pop and wraps FFFF→0000. It is cleared only by RESET; FLUSH does not clear it.

## Timing
- During and after RESET: FIFO_RESET=1, RDEN=0, M_VALID=0, M_DATA=0, BUSY=1, RD_COUNT=0.
- RESET released at edge k: FIFO_RESET high through cycle k+RST_CYCLES-1. SETTLE lasts RST_WAIT cycles. RUN and BUSY=0 begin at cycle k+RST_CYCLES+RST_WAIT.
- RDEN in cycle n with occ=0 → M_VALID=1 in cycle n+2 (latency 2).
- Sustained throughput is 1 word/cycle with EMPTY=0, ALMOSTEMPTY=0, M_READY=1. It is 1 word per 2 cycles while ALMOSTEMPTY=1.
- M_READY low: at most 2 RDENs are issued beyond the last pop. RDEN deasserts in the same cycle the condition fails.
- RESET or FLUSH mid-transfer: the Q word arriving the next cycle is not captured.

## Test plan
- Reset sequence, defaults: release RESET → FIFO_RESET high exactly 4 cycles, BUSY low exactly 12 cycles after release, and RDEN=0 throughout.
- Streaming: FIFO model holding 20 words, EMPTY/ALMOSTEMPTY modelled, M_READY=1 → 20 words out in order. RDEN→M_VALID latency is 2. Words with ALMOSTEMPTY=0 arrive back-to-back. No RDEN while EMPTY=1. RD_COUNT=20.
- Backpressure: M_READY=0 with 10 words queued → exactly 2 words buffered, RDEN stops. Random M_READY afterwards → no loss or duplication, and M_DATA stays stable while stalled.
- ALMOSTEMPTY=1 with 3 words → RDEN never high on consecutive cycles, and all 3 words are delivered.
- FLUSH while occ=2 and a read is in flight → M_VALID=0 next cycle and FIFO_RESET high 4 cycles. The next delivered word is the first written after the flush, and RD_COUNT is unchanged.
- RD_COUNT preloaded via 65535 pops, then one more pop → reads 0. EN=0 mid-stream → no new RDEN, and buffered words still drain.
